if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the pipelined MIPS core. It sits directly upstream of decode.
//  - Owns the PC register and the next-PC select: sequential, branch or jump.
//  - Drives the word address of the combinational instruction memory (IM).
//  - Latches the fetched word and PC+4 into the IF/ID pipeline register, which feeds GPR read, Ctrl and Extender.
//  - Supports stall (hold) and squash (bubble) requests from the hazard logic.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset.
//  IM_AW     5              IM word-address width; ImAdr = Pc[IM_AW+1:2].
// PORTS
//  Clk           in   1   clock; all state updates on rising edge.
//  Reset         in   1   asynchronous, active-low reset.
//  Stall         in   1   hold PC and IF/ID (load-use hazard).
//  Flush         in   1   load a bubble into IF/ID.
//  PcSel         in   1   branch taken (Branch && Zero), resolved in EX.
//  BranchPc      in   32  PC+4 of the branch instruction.
//  BranchOffset  in   32  sign-extended imm16 of the branch.
//  Jump          in   1   jump decoded in ID.
//  JumpAddr      in   26  instr[25:0] of the jump.
//  JumpPcHi      in   4   PC+4[31:28] of the jump instruction.
//  ImData        in   32  IM read data; combinational from ImAdr.
//  ImAdr         out  IM_AW  IM word address.
//  Pc            out  32  current fetch PC.
//  IfId_Instr    out  32  latched instruction; 0 (nop) when bubble.
//  IfId_PcPlus4  out  32  latched PC+4 of IfId_Instr.
//  IfId_Valid    out  1   1 = IfId_Instr is a real instruction.
// BEHAVIOUR
//  - Reset low, asynchronous and immediate:
//    - Pc = RESET_PC.
//    - IfId_Instr = 0, IfId_PcPlus4 = 0, IfId_Valid = 0.
//  - Targets, all arithmetic modulo 2^32 (wraps, no overflow flag):
//    - seq = Pc+4.
//    - br  = BranchPc + (BranchOffset<<2).
//    - jmp = {JumpPcHi, JumpAddr, 2'b00}.
//  - PC update priority per edge: PcSel > Jump > Stall > seq.
//    - Redirects override Stall.
//    - PcSel and Jump asserted together: branch target wins.
//  - IF/ID update priority per edge: PcSel | Jump | Flush > Stall > load.
//    - Bubble: IfId_Instr = 0, IfId_PcPlus4 = 0, IfId_Valid = 0.
//    - Stall: all IF/ID fields hold.
//    - Load: IfId_Instr = ImData, IfId_PcPlus4 = Pc+4, IfId_Valid = 1.
//  - Latency: the word at Pc appears on IfId_Instr one edge later.
//  - After reset release, the first edge latches IM[RESET_PC] and sets Pc = RESET_PC+4.
//  - ImAdr = Pc[IM_AW+1:2], purely combinational. Pc[1:0] are always 00.
//    - Misaligned targets are truncated by the shift/concatenation above.
//  - Reset asserted mid-stall or mid-redirect: reset wins with no residual state.
// CONFIGURATION
//  FETCH_STATS_EN defined: adds two output ports.
//    - FetchCnt (32): increments on each edge where IF/ID loads with IfId_Valid = 1.
//    - StallCnt (32): increments on each edge where Stall holds the stage with no redirect/Flush.
//    - Both clear to 0 on Reset and wrap at 2^32.
//  FETCH_STATS_EN undefined: the ports and counters do not exist. All other behaviour is identical.
// TESTING
//  1. Reset held low, then released.
//     - Pc = 0, IfId_Valid = 0.
//     - First edge: IfId_Instr = IM[0], IfId_PcPlus4 = 4, Pc = 4.
//  2. Sequential run, IM[0..3] = 0x11,0x22,0x33,0x44.
//     - After 3 edges: Pc = 0xC, IfId_Instr = 0x33, IfId_PcPlus4 = 0xC, ImAdr = 3.
//  3. Stall = 1 for 2 edges at Pc = 8.
//     - Pc stays 8, IF/ID holds 0x22/8/1.
//     - Stall drop: next edge loads 0x33.
//  4. PcSel = 1 with Stall = 1, BranchPc = 0x10, BranchOffset = 0xFFFF_FFFE.
//     - Pc = 0x8, IfId_Valid = 0, IfId_Instr = 0.
//  5. Jump = 1, JumpAddr = 26'h5, JumpPcHi = 0.
//     - Pc = 0x14, bubble in IF/ID.
//     - Repeat with PcSel = 1, BranchPc = 0x4, offset = 0: Pc = 0x4.
//  6. Wrap case: Pc forced to 0xFFFF_FFFC via jump, then sequential edge.
//     - Pc = 0, IfId_PcPlus4 = 0.
//     - Pull Reset low mid-cycle: outputs clear before the next edge.
//     - With FETCH_STATS_EN: FetchCnt and StallCnt read 0.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: MIPS fetch stage with PC register, next-PC select and IF/ID pipeline register.
// Optional FETCH_STATS_EN adds the FetchCnt/StallCnt counter ports.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             PcSel,
    input  logic [31:0]      BranchPc,
    input  logic [31:0]      BranchOffset,
    input  logic             Jump,
    input  logic [25:0]      JumpAddr,
    input  logic [3:0]       JumpPcHi,
    input  logic [31:0]      ImData,
    output logic [IM_AW-1:0] ImAdr,
    output logic [31:0]      Pc,
    output logic [31:0]      IfId_Instr,
    output logic [31:0]      IfId_PcPlus4,
    output logic             IfId_Valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]      FetchCnt,
    output logic [31:0]      StallCnt
`endif
);
    logic [31:0] seq_pc, br_pc, jmp_pc, next_pc;
    logic        redirect, bubble, load;

    always_comb begin
        seq_pc   = Pc + 32'd4;
        br_pc    = BranchPc + (BranchOffset << 2);
        jmp_pc   = {JumpPcHi, JumpAddr, 2'b00};
        redirect = PcSel | Jump;
        bubble   = redirect | Flush;
        load     = !bubble && !Stall;
        next_pc  = PcSel ? br_pc : Jump ? jmp_pc : Stall ? Pc : seq_pc;
    end

    assign ImAdr = Pc[IM_AW+1:2];

    // Low two bits are forced to zero so misaligned targets truncate.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            Pc <= {RESET_PC[31:2], 2'b00};
        else
            Pc <= {next_pc[31:2], 2'b00};
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            IfId_Instr   <= '0;
            IfId_PcPlus4 <= '0;
            IfId_Valid   <= 1'b0;
        end else if (bubble) begin
            IfId_Instr   <= '0;
            IfId_PcPlus4 <= '0;
            IfId_Valid   <= 1'b0;
        end else if (load) begin
            IfId_Instr   <= ImData;
            IfId_PcPlus4 <= seq_pc;
            IfId_Valid   <= 1'b1;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            FetchCnt <= '0;
            StallCnt <= '0;
        end else begin
            if (load)
                FetchCnt <= FetchCnt + 32'd1;
            if (Stall && !bubble)
                StallCnt <= StallCnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed plus randomized fetch-stage checks against a behavioural model.
module tb_if_stage;
    logic        Clk = 1'b0, Reset = 1'b0;
    logic        Stall = 0, Flush = 0, PcSel = 0, Jump = 0;
    logic [31:0] BranchPc = 0, BranchOffset = 0, ImData;
    logic [25:0] JumpAddr = 0;
    logic [3:0]  JumpPcHi = 0;
    logic [4:0]  ImAdr;
    logic [31:0] Pc, IfId_Instr, IfId_PcPlus4;
    logic        IfId_Valid;
`ifdef FETCH_STATS_EN
    logic [31:0] FetchCnt, StallCnt;
`endif
    logic [31:0] im [32];
    int          n_vec = 0, n_bad = 0;
    logic [31:0] m_pc, m_instr, m_pcp4, m_fetch, m_stall;
    logic        m_valid;

    if_stage dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .PcSel(PcSel),
        .BranchPc(BranchPc), .BranchOffset(BranchOffset), .Jump(Jump),
        .JumpAddr(JumpAddr), .JumpPcHi(JumpPcHi), .ImData(ImData), .ImAdr(ImAdr),
        .Pc(Pc), .IfId_Instr(IfId_Instr), .IfId_PcPlus4(IfId_PcPlus4), .IfId_Valid(IfId_Valid)
`ifdef FETCH_STATS_EN
        , .FetchCnt(FetchCnt), .StallCnt(StallCnt)
`endif
    );

    assign ImData = im[ImAdr];
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_pcp4 = 0; m_valid = 0; m_fetch = 0; m_stall = 0;
    endtask

    task automatic check_model();
        check("pc", Pc, m_pc);
        check("imadr", {27'd0, ImAdr}, {27'd0, m_pc[6:2]});
        check("instr", IfId_Instr, m_instr);
        check("pcplus4", IfId_PcPlus4, m_pcp4);
        check("valid", {31'd0, IfId_Valid}, {31'd0, m_valid});
`ifdef FETCH_STATS_EN
        check("fetchcnt", FetchCnt, m_fetch);
        check("stallcnt", StallCnt, m_stall);
`endif
    endtask

    // One rising edge: advance the model from the applied inputs, then compare.
    task automatic step();
        logic [31:0] nxt;
        @(posedge Clk);
        if (PcSel || Jump || Flush) begin
            m_instr = 0; m_pcp4 = 0; m_valid = 0;
        end else if (!Stall) begin
            m_instr = im[(m_pc / 4) % 32]; m_pcp4 = m_pc + 4; m_valid = 1;
            m_fetch = m_fetch + 1;
        end else
            m_stall = m_stall + 1;
        if (PcSel)      nxt = BranchPc + BranchOffset * 4;
        else if (Jump)  nxt = {JumpPcHi, JumpAddr, 2'b00};
        else if (Stall) nxt = m_pc;
        else            nxt = m_pc + 4;
        m_pc = nxt & 32'hFFFF_FFFC;
        #1;
        check_model();
    endtask

    task automatic drive(input logic s, f, p, j, input logic [31:0] bpc, boff,
                         input logic [25:0] ja, input logic [3:0] jh);
        Stall = s; Flush = f; PcSel = p; Jump = j;
        BranchPc = bpc; BranchOffset = boff; JumpAddr = ja; JumpPcHi = jh;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) im[i] = $urandom;
        im[0] = 32'h11; im[1] = 32'h22; im[2] = 32'h33; im[3] = 32'h44;
        model_reset();
        #12;
        check_model();
        @(negedge Clk) Reset = 1'b1;
        #1;
        step();
        check("t1 instr", IfId_Instr, 32'h11);
        check("t1 pc", Pc, 32'h4);
        step();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        check("t3 hold pc", Pc, 32'h8);
        check("t3 hold instr", IfId_Instr, 32'h22);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("t2 pc", Pc, 32'hC);
        check("t2 instr", IfId_Instr, 32'h33);
        check("t2 imadr", {27'd0, ImAdr}, 32'd3);
        drive(1, 0, 1, 0, 32'h10, 32'hFFFF_FFFE, 0, 0);
        step();
        check("t4 pc", Pc, 32'h8);
        check("t4 valid", {31'd0, IfId_Valid}, 32'd0);
        drive(0, 0, 0, 1, 0, 0, 26'h5, 4'h0);
        step();
        check("t5 jmp pc", Pc, 32'h14);
        drive(0, 0, 1, 1, 32'h4, 0, 26'h5, 4'h0);
        step();
        check("t5 br wins", Pc, 32'h4);
        drive(0, 0, 0, 1, 0, 0, 26'h3FF_FFFF, 4'hF);
        step();
        check("t6 pc max", Pc, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("t6 wrap pc", Pc, 32'h0);
        check("t6 wrap pcp4", IfId_PcPlus4, 32'h0);
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(3) == 0, $urandom_range(9) == 0, $urandom_range(9) == 0,
                  $urandom_range(9) == 0, $urandom, $urandom, 26'($urandom), 4'($urandom));
            step();
        end
        drive(1, 0, 1, 0, 32'h40, 32'h3, 0, 0);
        @(posedge Clk);
        #3 Reset = 1'b0;
        #1;
        model_reset();
        check_model();
        @(negedge Clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b1;
        #1;
        step();
        check("post reset pc", Pc, 32'h4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
